program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Host-side transmitter for the CPU instruction-load interface. Accepts a framed byte
//  stream (length header + big-endian words) over a valid/ready link, buffers the program,
//  and holds the CPU in reset while filling. It then drives LoadInstructions/Instruction
//  as one contiguous burst, pulses the CPU reset to zero the PC, and releases the CPU.
// PARAMETERS
//  DEPTH    32   max program words buffered (power of 2, >=2)
//  LEN_W    16   width of word-count header field
//  ADDR_W   $clog2(DEPTH)   buffer index width (derived, not overridable)
// PORTS
//  clk               in   1      system clock, all logic rising-edge
//  Reset_n           in   1      asynchronous, active-low reset
//  host_data         in   8      stream byte
//  host_valid        in   1      host_data valid
//  host_ready        out  1      loader accepts byte when valid&ready
//  LoadInstructions  out  1      to CPU: write Instruction at CPU load counter this cycle
//  Instruction       out  32     to CPU: instruction word
//  cpu_reset         out  1      to CPU Reset (active-high)
//  busy              out  1      high in any state except IDLE/RUN
//  done              out  1      high in RUN (program loaded, CPU running)
//  err               out  1      sticky; set on bad frame, cleared on next header start
// BEHAVIOUR
//  Reset (async): state=IDLE; host_ready=0; LoadInstructions=0; Instruction=0; cpu_reset=1;
//   busy=0; done=0; err=0; buffer contents undefined.
//  Frame: 2 header bytes (count, MSB first), then 4*count bytes, each word MSB first.
//  States: IDLE -> HDR -> FILL -> [CHK] -> BURST -> FLUSH -> RUN.
//  IDLE: host_ready=1 one cycle after reset release; first accepted byte = count[15:8], ->HDR.
//  HDR: accept count[7:0]. count==0 or count>DEPTH: set err, return to IDLE (no burst).
//   Otherwise clear word index, ->FILL.
//  FILL: host_ready=1; byte packer shifts bytes in; every 4th byte writes buffer[idx], idx++.
//   After word count-1 is written -> BURST (or CHK if checksum enabled). Stalls freely on
//   host_valid=0; no timeout.
//  cpu_reset=1 in IDLE/HDR/FILL/CHK/FLUSH; 0 in BURST/RUN.
//  BURST: host_ready=0; for k=0..count-1 on consecutive cycles: LoadInstructions=1,
//   Instruction=buffer[k] (registered outputs, word k appears k cycles after BURST entry).
//   Never gaps: CPU load counter advances every clock, so word k lands at CPU address k.
//  FLUSH: exactly 1 cycle, LoadInstructions=0, Instruction=0, cpu_reset=1 (zeroes PC and
//   pipeline garbage fetched during burst) -> RUN.
//  RUN: done=1, cpu_reset=0, host_ready=1. An accepted byte starts a new frame: it becomes
//   count[15:8], cpu_reset reasserts next cycle, done drops, err clears, ->HDR.
//  Simultaneous: in RUN/IDLE, valid&ready at the same edge as state entry is not possible
//   (ready registered, asserted only in the state). Reset_n low mid-burst aborts: CPU is
//   held in reset and memory may be partially written; host must resend the full frame.
//  Count is unsigned LEN_W bits; comparisons against DEPTH are done in LEN_W+1 bits.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: one extra trailing byte after the last word, XOR of all
//   2+4*count preceding bytes. CHK state accepts it; mismatch sets err and ->IDLE (no burst,
//   CPU stays in reset); match ->BURST.
//  Not defined: no CHK state, no trailing byte, FILL goes directly to BURST.
// STRUCTURE
//  Shared package loader_pkg: state encoding localparams (IDLE,HDR,FILL,CHK,BURST,FLUSH,RUN),
//   HDR_BYTES=2, BYTES_PER_WORD=4.
//  Sub-module byte_packer: 8->32 shift register with 2-bit byte counter, word_valid pulse,
//   synchronous clear; instantiated once. Buffer is a plain reg array in this module.
// TESTING
//  1 Reset then frame 00 02 | 20010005 | 2002000A -> host_ready after 1 cycle; 2-cycle
//    burst with Instruction 0x20010005 then 0x2002000A; 1-cycle cpu_reset; done=1.
//  2 Frame 00 03 with host_valid toggled every other cycle -> same burst contiguity
//    (3 back-to-back LoadInstructions), cpu_reset held 1 throughout fill.
//  3 Header 00 00 and header 00 21 (DEPTH=32) -> err=1, state IDLE, LoadInstructions never 1.
//  4 Reset_n low during 2nd burst cycle -> all outputs at reset values asynchronously,
//    cpu_reset=1; resend frame completes normally, err=0.
//  5 In RUN, send new frame 00 01 | FFFFFFFF -> done falls, cpu_reset=1 next cycle,
//    1-word burst, then RUN again.
//  6 LOADER_CHECKSUM_EN: frame 00 01 | 00000001 | chk 0x00 -> burst; chk 0x01 -> err, no burst.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_e        : loader FSM states
//   HDR_BYTES      : bytes in the word-count header
//   BYTES_PER_WORD : bytes packed into one instruction word
//   WORD_W         : instruction word width
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FILL,
        ST_CHK,
        ST_BURST,
        ST_FLUSH,
        ST_RUN
    } state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word packer: shifts bytes in MSB first and flags every 4th byte.
//   clk, rst_n   : clock, async active-low reset
//   clr          : synchronous clear of the byte counter
//   byte_valid   : byte_in is taken this cycle
//   byte_in      : incoming byte
//   word         : assembled word (valid together with word_valid)
//   word_valid   : combinational pulse on the cycle the final byte of a word arrives
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [1:0]          cnt_q, cnt_d;
    logic [WORD_W-9:0]   shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr) begin
            cnt_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[WORD_W-17:0], byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // The last byte bypasses the shift register so the word can be written
    // into the buffer on the same edge that accepts it.
    assign word       = {shift_q, byte_in};
    assign word_valid = byte_valid && !clr && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Host-side instruction loader. Receives a framed byte stream (2-byte word count,
// then big-endian words), buffers it while holding the CPU in reset, bursts the
// words to the CPU on consecutive cycles, pulses CPU reset once, then releases it.
//   clk, Reset_n        : clock, async active-low reset
//   host_data/valid     : input byte stream
//   host_ready          : byte accepted when host_valid & host_ready
//   LoadInstructions    : CPU write strobe, Instruction is the word
//   cpu_reset           : active-high CPU reset
//   busy / done / err   : status (err sticky until next header start)
// Optional feature: define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned LEN_W = 16
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic [7:0]  host_data,
    input  logic        host_valid,
    output logic        host_ready,
    output logic        LoadInstructions,
    output logic [31:0] Instruction,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned HI_W   = 8 * (HDR_BYTES - 1);
    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

    state_e state_q, state_d;

    logic [HI_W-1:0]    count_hi_q, count_hi_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0]  rd_idx_q, rd_idx_d;
    logic               err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    logic               ready_q, ready_d;
    logic               load_q, load_d;
    logic [WORD_W-1:0]  instr_q, instr_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0]  mem [DEPTH];

    logic               accept;
    logic [LEN_W-1:0]   hdr_count;
    logic               hdr_bad;
    logic               wr_last;
    logic               rd_last;
    logic [WORD_W-1:0]  pk_word;
    logic               pk_word_valid;

    assign accept    = host_valid && ready_q;
    assign hdr_count = LEN_W'({count_hi_q, host_data});
    assign hdr_bad   = (hdr_count == '0) || ({1'b0, hdr_count} > DEPTH_L);
    assign wr_last   = (LEN_W'(wr_idx_q) == (count_q - LEN_W'(1)));
    assign rd_last   = (LEN_W'(rd_idx_q) == (count_q - LEN_W'(1)));

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (Reset_n),
        .clr        ((state_q == ST_HDR) && accept),
        .byte_valid ((state_q == ST_FILL) && accept),
        .byte_in    (host_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_ff @(posedge clk) begin
        if (pk_word_valid) begin
            mem[wr_idx_q] <= pk_word;
        end
    end

    // State register
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        count_hi_d = count_hi_q;
        count_d    = count_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = '0;
        err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    count_hi_d = host_data;
                    err_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d      = host_data;
`endif
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ host_data;
`endif
                    if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        count_d  = hdr_count;
                        wr_idx_d = '0;
                        state_d  = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    chk_d = chk_q ^ host_data;
                end
`endif
                if (pk_word_valid) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_last) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_BURST;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (host_data != chk_q) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
            end
`endif
            ST_BURST: begin
                rd_idx_d = rd_idx_q + 1'b1;
                if (rd_last) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state so they line up with it.
    always_comb begin
        ready_d   = (state_d == ST_IDLE) || (state_d == ST_HDR) || (state_d == ST_FILL) ||
                    (state_d == ST_CHK)  || (state_d == ST_RUN);
        load_d    = (state_d == ST_BURST);
        cpu_rst_d = !((state_d == ST_BURST) || (state_d == ST_RUN));
        busy_d    = !((state_d == ST_IDLE) || (state_d == ST_RUN));
        done_d    = (state_d == ST_RUN);
        instr_d   = '0;
        if (load_d) begin
            // A one-word frame enters BURST on the edge that writes word 0.
            if (pk_word_valid && (wr_idx_q == rd_idx_d)) begin
                instr_d = pk_word;
            end else begin
                instr_d = mem[rd_idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_hi_q <= '0;
            count_q    <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
            ready_q    <= 1'b0;
            load_q     <= 1'b0;
            instr_q    <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            count_hi_q <= count_hi_d;
            count_q    <= count_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
            ready_q    <= ready_d;
            load_q     <= load_d;
            instr_q    <= instr_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign host_ready       = ready_q;
    assign LoadInstructions = load_q;
    assign Instruction      = instr_q;
    assign cpu_reset        = cpu_rst_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are queued as expected bursts when
// sent; an independent monitor checks every load strobe, burst length and the
// flush/run handoff. Define LOADER_CHECKSUM_EN to exercise the checksum byte.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic [7:0]  host_data;
    logic        host_valid;
    logic        host_ready;
    logic        LoadInstructions;
    logic [31:0] Instruction;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    program_loader #(.DEPTH(32), .LEN_W(16)) dut (
        .clk              (clk),
        .Reset_n          (Reset_n),
        .host_data        (host_data),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .cpu_reset        (cpu_reset),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          len_q[$];
    int          run = 0;
    bit          flush_chk = 1'b0;
    bit          abort_mon = 1'b0;
    logic [31:0] mon_e;
    logic [31:0] wq[$];
    bit          ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Monitor: every load must match the next queued word; a burst must be one
    // unbroken run of the frame's length, followed by one flush cycle then RUN.
    always @(negedge clk) begin
        if (abort_mon) begin
            run       = 0;
            flush_chk = 1'b0;
            abort_mon = 1'b0;
        end else if (LoadInstructions === 1'b1) begin
            run++;
            check("burst_cpu_reset", cpu_reset, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_load", LoadInstructions, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("instruction", Instruction, mon_e);
            end
        end else if (run > 0) begin
            if (len_q.size() == 0) check("burst_len_unexpected", run, 0);
            else                   check("burst_len", run, len_q.pop_front());
            check("flush_cpu_reset", cpu_reset, 1);
            check("flush_instr", Instruction, 0);
            check("flush_done", done, 0);
            run       = 0;
            flush_chk = 1'b1;
        end else if (flush_chk) begin
            check("run_done", done, 1);
            check("run_cpu_reset", cpu_reset, 0);
            flush_chk = 1'b0;
        end
    end

    // Entry and exit at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic r;
        host_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        host_data  = b;
        host_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            r = host_ready;
            @(posedge clk);
            #1;
            if (r) ok = 1'b1;
        end
        host_valid = 1'b0;
        if (!ok) timeout_fail("byte_accept");
    endtask

    // gapmode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..2.
    task automatic send_frame(input logic [31:0] words[$], input int cnt, input bit good,
                              input int gapmode, input bit corrupt_chk);
        logic [7:0] bytes[$];
        logic [7:0] x;
        logic [15:0] c16;
        int g;
        c16 = 16'(cnt);
        bytes.push_back(c16[15:8]);
        bytes.push_back(c16[7:0]);
        if (good) begin
            foreach (words[i]) begin
                bytes.push_back(words[i][31:24]);
                bytes.push_back(words[i][23:16]);
                bytes.push_back(words[i][15:8]);
                bytes.push_back(words[i][7:0]);
            end
`ifdef LOADER_CHECKSUM_EN
            x = 8'h00;
            foreach (bytes[i]) x = x ^ bytes[i];
            bytes.push_back(corrupt_chk ? (x ^ 8'h01) : x);
`else
            x = 8'h00;
`endif
            if (!corrupt_chk) begin
                foreach (words[i]) exp_q.push_back(words[i]);
                len_q.push_back(cnt);
            end
        end
        foreach (bytes[i]) begin
            g = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            send_byte(bytes[i], g);
            if (i == 0) begin
                check("hdr_err_clear", err, 0);
                check("hdr_done_drop", done, 0);
                check("hdr_cpu_reset", cpu_reset, 1);
                check("hdr_busy", busy, 1);
            end else if (i < bytes.size() - 1) begin
                check("fill_reset_busy", {cpu_reset, busy}, 2'b11);
            end
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int t = 0; t < 500 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) timeout_fail("wait_done");
        check("done_err", err, 0);
        check("done_busy", busy, 0);
        check("words_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    task automatic check_bad_header();
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_cpu_reset", cpu_reset, 1);
        repeat (3) begin @(posedge clk); #1; end
        check("bad_idle_ready", host_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        Reset_n    = 1'b0;
        host_valid = 1'b0;
        host_data  = 8'h00;
        #12;
        check("rst_ready", host_ready, 0);
        check("rst_load", LoadInstructions, 0);
        check("rst_instr", Instruction, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        Reset_n = 1'b1;
        #2;
        check("ready_before_edge", host_ready, 0);
        @(posedge clk); #1;
        check("ready_after_edge", host_ready, 1);

        // Two-word reference frame.
        wq.delete();
        wq.push_back(32'h20010005);
        wq.push_back(32'h2002000A);
        send_frame(wq, 2, 1'b1, 0, 1'b0);
        wait_done();

        // Three words with host_valid toggling.
        rand_words(3);
        send_frame(wq, 3, 1'b1, 1, 1'b0);
        wait_done();

        // Out-of-range headers.
        wq.delete();
        send_frame(wq, 0, 1'b0, 0, 1'b0);
        check_bad_header();
        send_frame(wq, 33, 1'b0, 0, 1'b0);
        check_bad_header();

        // Reset during the second burst cycle.
        rand_words(4);
        send_frame(wq, 4, 1'b1, 0, 1'b0);
        k = 0;
        for (int t = 0; t < 50 && k < 2; t++) begin
            if (LoadInstructions) k++;
            if (k < 2) begin @(posedge clk); #2; end
        end
        if (k < 2) timeout_fail("burst_start");
        Reset_n = 1'b0;
        abort_mon = 1'b1;
        exp_q.delete();
        len_q.delete();
        #1;
        check("abort_load", LoadInstructions, 0);
        check("abort_instr", Instruction, 0);
        check("abort_cpu_reset", cpu_reset, 1);
        check("abort_ready", host_ready, 0);
        check("abort_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1'b1;
        @(posedge clk); #1;
        wq.delete();
        wq.push_back(32'h20010005);
        wq.push_back(32'h2002000A);
        send_frame(wq, 2, 1'b1, 0, 1'b0);
        wait_done();

        // New frame straight from RUN.
        wq.delete();
        wq.push_back(32'hFFFFFFFF);
        send_frame(wq, 1, 1'b1, 0, 1'b0);
        wait_done();

        // Full-depth frame, then random frames with random gaps.
        rand_words(32);
        send_frame(wq, 32, 1'b1, 0, 1'b0);
        wait_done();
        for (int f = 0; f < 4; f++) begin
            k = int'($urandom_range(1, 32));
            rand_words(k);
            send_frame(wq, k, 1'b1, 2, 1'b0);
            wait_done();
        end

`ifdef LOADER_CHECKSUM_EN
        wq.delete();
        wq.push_back(32'h00000001);
        send_frame(wq, 1, 1'b1, 0, 1'b0);
        wait_done();
        send_frame(wq, 1, 1'b1, 0, 1'b1);
        check_bad_header();
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
